// File: rtl/vit_branch_sequencer.sv
// Viterbi branch sequencer: walks the 8 branches of a K=3 (7,5) trellis for each
// accepted symbol pair, then pulses commit, and frame_done after DEPTH steps.
module vit_branch_sequencer #(
  parameter int DEPTH = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       sym_ready,
  output logic       br_valid,
  output logic [1:0] br_state,
  output logic       br_bit,
  output logic [2:0] br_hdist,
  output logic       commit,
  output logic       frame_done,
  output logic [7:0] step_cnt,
  output logic       busy
);

  localparam logic [7:0] LP_DEPTH = 8'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BRANCH, S_COMMIT, S_FLUSH} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_slot;
  logic [1:0] r_sym_q;
  logic [7:0] r_step_cnt;
  logic       w_accept;
  logic       w_last_step;
  logic       w_c0;
  logic       w_c1;
  logic [1:0] w_diff;

  // Handshake: a symbol transfers on a cycle where sym_valid && sym_ready;
  // sym_ready is only ever high in IDLE, and sym_in is ignored otherwise.
  assign sym_ready   = (r_state == S_IDLE) && !abort && !rst;
  assign w_accept    = sym_valid && sym_ready;
  assign w_last_step = (r_step_cnt + 8'd1) == LP_DEPTH;
  assign step_cnt    = r_step_cnt;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_BRANCH;
      S_BRANCH: if (r_slot == 3'd7) w_next = S_COMMIT;
      S_COMMIT: w_next = w_last_step ? S_FLUSH : S_IDLE;
      S_FLUSH:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Branch outputs; slot = {s1, s0, u}, generators 7 and 5 octal.
  always_comb begin
    br_valid = (r_state == S_BRANCH);
    br_state = 2'b00;
    br_bit   = 1'b0;
    br_hdist = 3'd0;
    w_c0     = r_slot[0] ^ r_slot[2] ^ r_slot[1];
    w_c1     = r_slot[0] ^ r_slot[1];
    w_diff   = {w_c0, w_c1} ^ r_sym_q;
    if (br_valid) begin
      br_state = r_slot[2:1];
      br_bit   = r_slot[0];
      br_hdist = {2'b00, w_diff[1]} + {2'b00, w_diff[0]};
    end
  end

  // An abort in COMMIT/FLUSH suppresses the pulse so the metric unit never latches.
  assign commit     = (r_state == S_COMMIT) && !abort;
  assign frame_done = (r_state == S_FLUSH) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_slot     <= 3'd0;
      r_sym_q    <= 2'b00;
      r_step_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (abort) begin
        r_slot     <= 3'd0;
        r_step_cnt <= 8'd0;
      end else begin
        if (w_accept) begin
          r_sym_q <= sym_in;
          r_slot  <= 3'd0;
        end
        if (r_state == S_BRANCH) r_slot <= r_slot + 3'd1;
        if (r_state == S_COMMIT) r_step_cnt <= r_step_cnt + 8'd1;
        if (r_state == S_FLUSH)  r_step_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_vit_branch_sequencer.sv
// Randomized bench for vit_branch_sequencer against a per-symbol timeline model.
module tb_vit_branch_sequencer;

  localparam int DEPTH = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       sym_valid;
  logic [1:0] sym_in;
  logic       sym_ready;
  logic       br_valid;
  logic [1:0] br_state;
  logic       br_bit;
  logic [2:0] br_hdist;
  logic       commit;
  logic       frame_done;
  logic [7:0] step_cnt;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: m_pos counts cycles since the symbol was accepted (0 = waiting).
  int m_pos   = 0;
  int m_sym   = 0;
  int m_steps = 0;
  int n_commits = 0;
  int n_frames  = 0;
  int n_resets  = 0;

  logic [18:0] exp_q[$];

  vit_branch_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .abort(abort), .sym_valid(sym_valid), .sym_in(sym_in),
    .sym_ready(sym_ready), .br_valid(br_valid), .br_state(br_state), .br_bit(br_bit),
    .br_hdist(br_hdist), .commit(commit), .frame_done(frame_done),
    .step_cnt(step_cnt), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Convolutional encoder output for shift register {u, s1, s0}, G = (111, 101).
  function automatic int code_dist(input int st, input int u, input int sym);
    logic [2:0] sr;
    logic [1:0] code;
    logic [1:0] s;
    logic [1:0] d;
    sr   = {u[0], st[1:0]};
    code = {^(sr & 3'b111), ^(sr & 3'b101)};
    s    = sym[1:0];
    d    = code ^ s;
    return int'(d[0]) + int'(d[1]);
  endfunction

  function automatic logic [18:0] model_expect(input logic ab);
    logic [18:0] e;
    int slot;
    e = '0;
    e[18] = (m_pos == 0) && !ab;
    if (m_pos >= 1 && m_pos <= 8) begin
      slot    = m_pos - 1;
      e[17]   = 1'b1;
      e[16:15] = 2'(slot / 2);
      e[14]   = 1'(slot % 2);
      e[13:11] = 3'(code_dist(slot / 2, slot % 2, m_sym));
    end
    e[10]  = (m_pos == 9) && !ab;
    e[9]   = (m_pos == 10) && !ab;
    e[8:1] = 8'(m_steps);
    e[0]   = (m_pos != 0);
    return e;
  endfunction

  task automatic model_step(input logic ab, input logic sv, input logic [1:0] si);
    if (ab) begin
      m_pos = 0;
      m_steps = 0;
    end else if (m_pos == 0) begin
      if (sv) begin
        m_pos = 1;
        m_sym = int'(si);
      end
    end else if (m_pos <= 8) begin
      m_pos++;
    end else if (m_pos == 9) begin
      m_steps++;
      n_commits++;
      m_pos = (m_steps == DEPTH) ? 10 : 0;
    end else begin
      m_steps = 0;
      n_frames++;
      m_pos = 0;
    end
  endtask

  task automatic compare_outputs();
    logic [18:0] e;
    e = exp_q.pop_front();
    check("sym_ready",  32'(sym_ready),  32'(e[18]));
    check("br_valid",   32'(br_valid),   32'(e[17]));
    check("br_state",   32'(br_state),   32'(e[16:15]));
    check("br_bit",     32'(br_bit),     32'(e[14]));
    check("br_hdist",   32'(br_hdist),   32'(e[13:11]));
    check("commit",     32'(commit),     32'(e[10]));
    check("frame_done", 32'(frame_done), 32'(e[9]));
    check("step_cnt",   32'(step_cnt),   32'(e[8:1]));
    check("busy",       32'(busy),       32'(e[0]));
  endtask

  // Asynchronous reset mid-cycle: outputs must collapse before any clock edge.
  task automatic drive_async_reset();
    rst = 1'b1;
    #1;
    m_pos = 0;
    m_steps = 0;
    n_resets++;
    exp_q.push_back(19'd0);
    compare_outputs();
    @(posedge clk);
    #1;
    exp_q.push_back(19'd0);
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic ab;
    logic sv;
    logic [1:0] si;
    rst = 1'b1;
    abort = 1'b0;
    sym_valid = 1'b0;
    sym_in = 2'b00;
    repeat (2) @(negedge clk);
    exp_q.push_back(19'd0);
    compare_outputs();
    rst = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      cyc = i;
      // Mid-BRANCH reset at a few points in the run.
      if ((i == 700 || i == 3100 || i == 4800) && m_pos >= 1 && m_pos <= 8) begin
        drive_async_reset();
      end else if ((i == 701 || i == 3101 || i == 4801) && n_resets == 0) begin
        drive_async_reset();
      end
      ab = (i >= 2500) && ($urandom_range(0, 29) == 0);
      sv = ($urandom_range(0, 9) < 8);
      si = 2'($urandom_range(0, 3));
      abort = ab;
      sym_valid = sv;
      sym_in = si;
      #1;
      exp_q.push_back(model_expect(ab));
      compare_outputs();
      model_step(ab, sv, si);
      @(negedge clk);
    end

    check("commits_seen", 32'(n_commits > 100), 32'd1);
    check("frames_seen",  32'(n_frames > 2),    32'd1);
    check("resets_seen",  32'(n_resets > 0),    32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vit_branch_sequencer.md
VIT_BRANCH_SEQUENCER -- requirements
Module: vit_branch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 15, meaning trellis steps per decode frame; legal range 2..255.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port abort  input  1  synchronous frame abort.
REQ-005 SHALL have port sym_valid  input  1  received symbol pair offered.
REQ-006 SHALL have port sym_in  input  2  received code bits {c0,c1}.
REQ-007 SHALL have port sym_ready  output  1  block accepts sym_in this cycle.
REQ-008 SHALL have port br_valid  output  1  branch slot presented to the path metric unit.
REQ-009 SHALL have port br_state  output  2  current trellis state of the branch.
REQ-010 SHALL have port br_bit  output  1  hypothesised input bit of the branch.
REQ-011 SHALL have port br_hdist  output  3  Hamming distance, expected vs latched symbol.
REQ-012 SHALL have port commit  output  1  one-cycle pulse: metric unit latches new metrics and survivors.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse: DEPTH steps completed.
REQ-014 SHALL have port step_cnt  output  8  steps committed in the current frame.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BRANCH, COMMIT, FLUSH.
REQ-017 sym_ready SHALL equal (state==IDLE) && !abort && !rst; a symbol is accepted on a cycle with sym_valid && sym_ready.
REQ-018 On acceptance, SHALL latch sym_in into sym_q, clear the 3-bit slot counter, and enter BRANCH.
REQ-019 In BRANCH, SHALL drive br_valid=1, br_state=slot[2:1], br_bit=slot[0], increment slot each cycle for exactly 8 cycles (slot 0..7), and enter COMMIT after slot 7.
REQ-020 Expected code for state s={s1,s0} and bit u SHALL be c0=u^s1^s0, c1=u^s0 (generators 7,5 octal); next state is {u,s1}.
REQ-021 br_hdist SHALL be the popcount of ({c0,c1} XOR sym_q), range 0..2, zero-extended to 3 bits; br_hdist SHALL be 0 whenever br_valid=0.
REQ-022 br_state and br_bit SHALL be 0 whenever br_valid=0.
REQ-023 COMMIT SHALL last one cycle with commit=1; step_cnt SHALL increment by 1 on that cycle's clock edge.
REQ-024 From COMMIT, SHALL go to FLUSH if the incremented step_cnt equals DEPTH, otherwise to IDLE.
REQ-025 FLUSH SHALL last one cycle with frame_done=1, clear step_cnt to 0, then go to IDLE.
REQ-026 Throughput SHALL be one symbol per 10 cycles, or 11 cycles for the frame's final step.
REQ-027 abort SHALL take priority over all FSM transitions: on the next edge the FSM goes to IDLE, step_cnt and slot clear, and no commit or frame_done is emitted; abort in IDLE blocks acceptance that cycle.
REQ-028 sym_valid while not ready SHALL be ignored; sym_in SHALL not be sampled outside acceptance.

Reset
REQ-029 While rst=1, SHALL force state IDLE; slot, sym_q and step_cnt to 0; and all outputs to 0, including sym_ready.
REQ-030 rst asserted mid-operation SHALL take effect immediately (asynchronously), discarding the in-flight step.
REQ-031 After rst deasserts, sym_ready SHALL be 1 in the first cycle if abort=0.

Verification
REQ-032 Reset: rst=1 in mid-BRANCH -> same cycle, br_valid=0, commit=0, step_cnt=0, sym_ready=0; after release, sym_ready=1.
REQ-033 Accept sym_in=2'b00 at cycle T -> br_valid=1 for T+1..T+8 with (br_state,br_bit)=(0,0),(0,1),(1,0),(1,1),(2,0),(2,1),(3,0),(3,1) and br_hdist=0,2,2,0,1,1,1,1; commit=1 at T+9; sym_ready=1 at T+10.
REQ-034 Accept sym_in=2'b11 -> br_hdist sequence 2,0,0,2,1,1,1,1.
REQ-035 DEPTH=15 with sym_valid held high -> 15 commit pulses spaced 10 cycles apart; frame_done one cycle after the 15th commit; step_cnt returns to 0; next acceptance one cycle later.
REQ-036 abort=1 during BRANCH slot 3 -> next cycle br_valid=0, state IDLE, step_cnt=0, no commit; sym_ready=1 the cycle after abort drops.
REQ-037 sym_valid asserted during BRANCH/COMMIT/FLUSH with sym_in changing -> no extra acceptance, and br_hdist reflects only the latched symbol.
